sirv_gnrl_vrfifo: RTL and testbench
===================================

SIRV_GNRL_VRFIFO -- requirements
Module: sirv_gnrl_vrfifo

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter DP, default 4, depth in entries; legal values 2, 4, 8, 16 (power of two).
REQ-003 Parameter CUT_READY, default 0; 1 = i_rdy depends only on internal state, 0 = i_rdy may depend on o_rdy.
REQ-004 Ports SHALL be:
  clk    input   1         single clock, all state on rising edge
  rst_n  input   1         asynchronous active-low reset
  i_vld  input   1         writer presents data
  i_rdy  output  1         FIFO accepts data
  i_dat  input   DW        write data
  o_vld  output  1         FIFO presents data
  o_rdy  input   1         reader accepts data
  o_dat  output  DW        read data (head entry)
  cnt    output  log2(DP)+1  current occupancy, 0..DP
REQ-005 Clock SHALL be named clk; reset SHALL be named rst_n, asynchronous, active-low; no other clock or reset.

Function
REQ-006 Write event (wen) SHALL be i_vld & i_rdy; read event (ren) SHALL be o_vld & o_rdy.
REQ-007 Storage SHALL be DP entries of DW bits, written only on wen, without reset (load-enable flops).
REQ-008 Write pointer and read pointer SHALL be log2(DP)+1 bits each (index + wrap bit), incremented by 1 on wen / ren respectively, wrapping modulo 2*DP.
REQ-009 empty SHALL be (wptr == rptr); full SHALL be index bits equal and wrap bits different.
REQ-010 o_vld SHALL equal !empty; o_dat SHALL equal the entry at rptr index, combinationally from storage; o_dat is don't-care while o_vld=0.
REQ-011 Write-to-read latency SHALL be 1 cycle: data written at edge N is visible on o_dat with o_vld=1 after edge N; no combinational bypass from i_dat to o_dat.
REQ-012 CUT_READY=1: i_rdy SHALL equal !full.
REQ-013 CUT_READY=0: i_rdy SHALL equal !full | o_rdy; a write into a full FIFO SHALL be accepted only in the same cycle as a read, and overwrites the freed head slot.
REQ-014 Simultaneous wen and ren SHALL leave cnt unchanged and advance both pointers.
REQ-015 cnt SHALL be wptr - rptr (modulo 2*DP), always within 0..DP.
REQ-016 o_vld, o_dat SHALL not change on a cycle with o_vld=1 & o_rdy=0 unless reset asserts (data stable under backpressure).
REQ-017 i_vld=1 with i_rdy=0 SHALL have no effect on state; o_rdy with o_vld=0 SHALL have no effect.
REQ-018 No overflow or underflow SHALL be possible through the interface; pointers SHALL never pass each other.

Reset
REQ-019 While rst_n=0, wptr=0, rptr=0, cnt=0, o_vld=0, and i_rdy=1, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard all entries immediately (o_vld falls asynchronously); storage contents are not cleared.
REQ-021 First write SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-022 Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles with o_rdy=0, DP=4 -> cnt 1,2,3,4; i_rdy=0 after fourth write (CUT_READY=1); o_dat=0x11 stable throughout.
REQ-023 Full FIFO DP=4, CUT_READY=0, i_vld=1 i_dat=0x55, o_rdy=1 for one cycle -> 0x11 read, 0x55 written, cnt stays 4, next o_dat=0x22.
REQ-024 Same as REQ-023 with CUT_READY=1 -> i_rdy=0, only read occurs, cnt goes 4->3, 0x55 not stored.
REQ-025 Stream 2*DP+3 words with i_vld=o_rdy=1 continuously -> output sequence equals input in order, pointer wrap exercised, cnt never exceeds 1 after fill.
REQ-026 Empty FIFO, o_rdy=1, i_vld=0 -> o_vld=0, cnt=0, pointers unchanged; single write 0xA5 -> o_vld=1 exactly one cycle later with o_dat=0xA5.
REQ-027 FIFO holding 3 entries, assert rst_n=0 between clock edges -> o_vld=0, cnt=0, i_rdy=1 immediately; after release, first read data equals the first post-reset write.

Source files
------------

// File: rtl/sirv_gnrl_vrfifo.sv
// sirv_gnrl_vrfifo: valid/ready FIFO with wrap-bit pointers and unreset storage
module sirv_gnrl_vrfifo #(
    parameter int DW        = 32,
    parameter int DP        = 4,
    parameter bit CUT_READY = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_vld,
    output logic                   i_rdy,
    input  logic [DW-1:0]          i_dat,
    output logic                   o_vld,
    input  logic                   o_rdy,
    output logic [DW-1:0]          o_dat,
    output logic [$clog2(DP):0]    cnt
);
    localparam int AW = $clog2(DP);

    logic [AW:0]   wptr, rptr;
    logic [DW-1:0] mem [DP];
    logic          empty, full, wen, ren;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign i_rdy = CUT_READY ? !full : (!full || o_rdy);
    assign o_vld = !empty;
    assign wen   = i_vld && i_rdy;
    assign ren   = o_vld && o_rdy;
    assign o_dat = mem[rptr[AW-1:0]];
    assign cnt   = wptr - rptr;

    // pointers advance on their handshake and wrap through the extra bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wen) wptr <= wptr + (AW+1)'(1);
            if (ren) rptr <= rptr + (AW+1)'(1);
        end
    end

    // storage is load-enable only, contents survive reset
    always_ff @(posedge clk) begin
        if (wen) mem[wptr[AW-1:0]] <= i_dat;
    end
endmodule

// File: tb/tb_sirv_gnrl_vrfifo.sv
// tb_sirv_gnrl_vrfifo: directed scoreboard bench covering both ready modes
module tb_sirv_gnrl_vrfifo;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_vld, o_rdy;
    logic [31:0] i_dat;
    logic        rdy [2];
    logic        vld [2];
    logic [31:0] dat [2];
    logic [2:0]  cnt_o [2];

    logic [31:0] q0[$], q1[$];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sirv_gnrl_vrfifo #(.DW(32), .DP(DP), .CUT_READY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(rdy[0]), .i_dat(i_dat),
        .o_vld(vld[0]), .o_rdy(o_rdy), .o_dat(dat[0]), .cnt(cnt_o[0]));

    sirv_gnrl_vrfifo #(.DW(32), .DP(DP), .CUT_READY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(rdy[1]), .i_dat(i_dat),
        .o_vld(vld[1]), .o_rdy(o_rdy), .o_dat(dat[1]), .cnt(cnt_o[1]));

    // compare one DUT against its model occupancy/head
    task automatic chk(input int k, input int sz, input logic [31:0] hd, input string tag);
        logic er;
        er = (k == 1) ? (sz < DP) : ((sz < DP) || o_rdy);
        checks++;
        assert (rdy[k] === er) else begin
            fails++;
            $error("FAIL %s dut%0d i_rdy got %0b exp %0b", tag, k, rdy[k], er);
        end
        checks++;
        assert (vld[k] === (sz != 0)) else begin
            fails++;
            $error("FAIL %s dut%0d o_vld got %0b exp %0b", tag, k, vld[k], sz != 0);
        end
        checks++;
        assert (cnt_o[k] === 3'(sz)) else begin
            fails++;
            $error("FAIL %s dut%0d cnt got %0d exp %0d", tag, k, cnt_o[k], sz);
        end
        if (sz != 0) begin
            checks++;
            assert (dat[k] === hd) else begin
                fails++;
                $error("FAIL %s dut%0d o_dat got %h exp %h", tag, k, dat[k], hd);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk(0, q0.size(), q0.size() != 0 ? q0[0] : 32'h0, tag);
        chk(1, q1.size(), q1.size() != 0 ? q1[0] : 32'h0, tag);
    endtask

    // drive one cycle from a negedge, check, then update scoreboards at the posedge
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input string tag);
        bit ren0, wen0, ren1, wen1;
        i_vld = v;
        i_dat = d;
        o_rdy = r;
        #1;
        check_all(tag);
        ren0 = (q0.size() != 0) && r;
        wen0 = v && ((q0.size() < DP) || r);
        ren1 = (q1.size() != 0) && r;
        wen1 = v && (q1.size() < DP);
        @(posedge clk);
        if (ren0) void'(q0.pop_front());
        if (wen0) q0.push_back(d);
        if (ren1) void'(q1.pop_front());
        if (wen1) q1.push_back(d);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        i_vld = 1'b0;
        o_rdy = 1'b0;
        i_dat = '0;
        #2;
        check_all("reset_hold");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b1, 32'h11, 1'b0, "fill1");
        cycle(1'b1, 32'h22, 1'b0, "fill2");
        cycle(1'b1, 32'h33, 1'b0, "fill3");
        cycle(1'b1, 32'h44, 1'b0, "fill4");
        cycle(1'b1, 32'h99, 1'b0, "full_reject");
        cycle(1'b1, 32'h55, 1'b1, "full_rdwr");
        check_all("after_full_rdwr");
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, "drain");

        for (int i = 0; i < 2 * DP + 3; i++)
            cycle(1'b1, 32'h100 + 32'(i), 1'b1, $sformatf("stream%0d", i));
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, "stream_tail");

        cycle(1'b0, 32'h0, 1'b1, "empty_idle");
        cycle(1'b1, 32'hA5, 1'b0, "write_a5");
        cycle(1'b0, 32'h0, 1'b0, "see_a5");
        cycle(1'b0, 32'h0, 1'b1, "read_a5");

        cycle(1'b1, 32'hC1, 1'b0, "pre_rst1");
        cycle(1'b1, 32'hC2, 1'b0, "pre_rst2");
        cycle(1'b1, 32'hC3, 1'b0, "pre_rst3");
        i_vld = 1'b0;
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, 32'h77, 1'b0, "post_rst_wr");
        cycle(1'b1, 32'h78, 1'b0, "post_rst_wr2");
        cycle(1'b0, 32'h0, 1'b1, "post_rst_rd");
        cycle(1'b0, 32'h0, 1'b1, "post_rst_rd2");
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
